// File: rtl/ir_key_entry.sv
// IR remote keypad entry: debounces repeated codes, collects up to four BCD
// digits with BACK/CLEAR editing, and hands a completed entry to a consumer.
module ir_key_entry #(
  parameter int unsigned HOLDOFF    = 200000,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  code,
  input  logic        press,
  input  logic        entry_ready,
  output logic [15:0] entry_value,
  output logic        entry_valid,
  output logic [2:0]  digit_cnt,
  output logic [15:0] buf_bcd,
  output logic        key_strobe,
  output logic        key_err
);

  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;
  typedef enum logic [2:0] {K_DIGIT, K_ENTER, K_BACK, K_CLEAR, K_UNKNOWN} kind_t;

  state_t        state;
  logic          press_q;
  logic [7:0]    last_code;
  logic [HW-1:0] hcnt;

  kind_t         kind_c;
  logic [3:0]    digit_c;
  logic          event_c;
  logic          accept_c;
  logic          reject_c;

  // Translate the remote's key code into a key class and digit value.
  always_comb begin
    kind_c  = K_UNKNOWN;
    digit_c = 4'h0;
    case (code)
      8'h16: begin kind_c = K_DIGIT; digit_c = 4'd0; end
      8'h0C: begin kind_c = K_DIGIT; digit_c = 4'd1; end
      8'h18: begin kind_c = K_DIGIT; digit_c = 4'd2; end
      8'h5E: begin kind_c = K_DIGIT; digit_c = 4'd3; end
      8'h08: begin kind_c = K_DIGIT; digit_c = 4'd4; end
      8'h1C: begin kind_c = K_DIGIT; digit_c = 4'd5; end
      8'h5A: begin kind_c = K_DIGIT; digit_c = 4'd6; end
      8'h42: begin kind_c = K_DIGIT; digit_c = 4'd7; end
      8'h52: begin kind_c = K_DIGIT; digit_c = 4'd8; end
      8'h4A: begin kind_c = K_DIGIT; digit_c = 4'd9; end
      8'h43: kind_c = K_ENTER;
      8'h44: kind_c = K_BACK;
      8'h45: kind_c = K_CLEAR;
      default: kind_c = K_UNKNOWN;
    endcase
  end

  // Classify a press edge as accepted, rejected, or silently dropped as a repeat.
  always_comb begin
    event_c  = press & ~press_q & ~((code == last_code) && (hcnt < HW'(HOLDOFF)));
    accept_c = 1'b0;
    reject_c = 1'b0;
    if (event_c) begin
      if (state == HOLD) begin
        reject_c = 1'b1;
      end else begin
        case (kind_c)
          K_DIGIT: accept_c = (digit_cnt < 3'(MAX_DIGITS));
          K_BACK:  accept_c = (digit_cnt != 3'd0);
          K_ENTER: accept_c = (digit_cnt != 3'd0);
          K_CLEAR: accept_c = 1'b1;
          default: accept_c = 1'b0;
        endcase
        reject_c = ~accept_c;
      end
    end
  end

  // Entry state machine, digit buffer, repeat holdoff and key pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      press_q     <= 1'b0;
      last_code   <= 8'h00;
      hcnt        <= HW'(HOLDOFF);
      buf_bcd     <= 16'h0000;
      digit_cnt   <= 3'd0;
      entry_value <= 16'h0000;
      entry_valid <= 1'b0;
      key_strobe  <= 1'b0;
      key_err     <= 1'b0;
    end else begin
      press_q    <= press;
      key_strobe <= accept_c;
      key_err    <= reject_c;

      if (accept_c) begin
        last_code <= code;
        hcnt      <= '0;
      end else if (hcnt < HW'(HOLDOFF)) begin
        hcnt <= hcnt + HW'(1);
      end

      case (state)
        IDLE, ENTRY: begin
          if (accept_c) begin
            case (kind_c)
              K_DIGIT: begin
                buf_bcd   <= {buf_bcd[11:0], digit_c};
                digit_cnt <= digit_cnt + 3'd1;
                state     <= ENTRY;
              end
              K_BACK: begin
                buf_bcd   <= {4'h0, buf_bcd[15:4]};
                digit_cnt <= digit_cnt - 3'd1;
                if (digit_cnt == 3'd1) state <= IDLE;
              end
              K_CLEAR: begin
                buf_bcd   <= 16'h0000;
                digit_cnt <= 3'd0;
                state     <= IDLE;
              end
              K_ENTER: begin
                entry_value <= buf_bcd;
                entry_valid <= 1'b1;
                state       <= HOLD;
              end
              default: state <= state;
            endcase
          end
        end
        HOLD: begin
          if (entry_valid && entry_ready) begin
            entry_valid <= 1'b0;
            buf_bcd     <= 16'h0000;
            digit_cnt   <= 3'd0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_key_entry.sv
// Directed bench for ir_key_entry with a shortened holdoff window.
module tb_ir_key_entry;

  localparam int unsigned HOLDOFF = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  code = 8'h00;
  logic        press = 1'b0;
  logic        entry_ready = 1'b0;
  logic [15:0] entry_value;
  logic        entry_valid;
  logic [2:0]  digit_cnt;
  logic [15:0] buf_bcd;
  logic        key_strobe;
  logic        key_err;

  int errors = 0;
  int checks = 0;
  logic s_seen, e_seen;

  ir_key_entry #(.HOLDOFF(HOLDOFF), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .press(press),
    .entry_ready(entry_ready), .entry_value(entry_value),
    .entry_valid(entry_valid), .digit_cnt(digit_cnt), .buf_bcd(buf_bcd),
    .key_strobe(key_strobe), .key_err(key_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    int          gap;
    logic        s;
    logic        e;
    logic [2:0]  cnt;
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Two-cycle press; pulses are sampled just after the edge ending the event cycle.
  task automatic key(input logic [7:0] c, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    code  = c;
    press = 1'b1;
    @(posedge clk);
    #1;
    s_seen = key_strobe;
    e_seen = key_err;
    @(negedge clk);
    @(negedge clk);
    press = 1'b0;
  endtask

  initial begin
    int bad;

    vecs[0]  = '{8'h99, 3,   1'b0, 1'b1, 3'd0, 16'h0000};
    vecs[1]  = '{8'h43, 3,   1'b0, 1'b1, 3'd0, 16'h0000};
    vecs[2]  = '{8'h08, 3,   1'b1, 1'b0, 3'd1, 16'h0004};
    vecs[3]  = '{8'h16, 3,   1'b1, 1'b0, 3'd2, 16'h0040};
    vecs[4]  = '{8'h52, 3,   1'b1, 1'b0, 3'd3, 16'h0408};
    vecs[5]  = '{8'h4A, 3,   1'b1, 1'b0, 3'd4, 16'h4089};
    vecs[6]  = '{8'h1C, 3,   1'b0, 1'b1, 3'd4, 16'h4089};
    vecs[7]  = '{8'h45, 3,   1'b1, 1'b0, 3'd0, 16'h0000};
    vecs[8]  = '{8'h0C, 3,   1'b1, 1'b0, 3'd1, 16'h0001};
    vecs[9]  = '{8'h18, 3,   1'b1, 1'b0, 3'd2, 16'h0012};
    vecs[10] = '{8'h44, 3,   1'b1, 1'b0, 3'd1, 16'h0001};
    vecs[11] = '{8'h44, 250, 1'b1, 1'b0, 3'd0, 16'h0000};
    vecs[12] = '{8'h44, 250, 1'b0, 1'b1, 3'd0, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(entry_valid), 32'd0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_buf", 32'(buf_bcd), 32'd0);
    chk("rst_pulses", 32'({key_strobe, key_err}), 32'd0);
    rst_n = 1'b1;

    // Table of single key events
    for (int i = 0; i < 13; i++) begin
      key(vecs[i].code, vecs[i].gap);
      chk($sformatf("v%0d_strobe", i), 32'(s_seen), 32'(vecs[i].s));
      chk($sformatf("v%0d_err", i), 32'(e_seen), 32'(vecs[i].e));
      chk($sformatf("v%0d_cnt", i), 32'(digit_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_buf", i), 32'(buf_bcd), 32'(vecs[i].bcd));
    end

    // Entry, long hold, single-cycle handshake; stray ready ignored mid-entry
    key(8'h0C, 3);
    key(8'h18, 3);
    @(negedge clk) entry_ready = 1'b1;
    @(negedge clk) entry_ready = 1'b0;
    chk("stray_ready_cnt", 32'(digit_cnt), 32'd2);
    chk("stray_ready_valid", 32'(entry_valid), 32'd0);
    key(8'h5E, 3);
    key(8'h43, 3);
    chk("enter_strobe", 32'(s_seen), 32'd1);
    chk("enter_valid", 32'(entry_valid), 32'd1);
    chk("enter_value", 32'(entry_value), 32'h0123);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (entry_valid !== 1'b1 || entry_value !== 16'h0123) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    entry_ready = 1'b1;
    @(negedge clk);
    entry_ready = 1'b0;
    chk("hs_valid", 32'(entry_valid), 32'd0);
    chk("hs_cnt", 32'(digit_cnt), 32'd0);
    chk("hs_buf", 32'(buf_bcd), 32'd0);

    // Same-code holdoff window
    key(8'h5A, 3);
    chk("ho1_strobe", 32'(s_seen), 32'd1);
    key(8'h5A, 45);
    chk("ho2_pulses", 32'({s_seen, e_seen}), 32'd0);
    chk("ho2_cnt", 32'(digit_cnt), 32'd1);
    key(8'h5A, 200);
    chk("ho3_strobe", 32'(s_seen), 32'd1);
    chk("ho3_buf", 32'(buf_bcd), 32'h0066);

    // CLEAR in the handshake cycle: handshake completes, key rejected
    key(8'h45, 3);
    key(8'h0C, 3);
    key(8'h43, 3);
    chk("hold2_valid", 32'(entry_valid), 32'd1);
    chk("hold2_value", 32'(entry_value), 32'h0001);
    @(negedge clk);
    code = 8'h45;
    press = 1'b1;
    entry_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hsk_err", 32'(key_err), 32'd1);
    chk("hsk_strobe", 32'(key_strobe), 32'd0);
    chk("hsk_valid", 32'(entry_valid), 32'd0);
    chk("hsk_cnt", 32'(digit_cnt), 32'd0);
    chk("hsk_buf", 32'(buf_bcd), 32'd0);
    @(negedge clk) entry_ready = 1'b0;
    @(negedge clk) press = 1'b0;

    // Asynchronous reset mid-entry, then the same code is accepted at once
    key(8'h18, 3);
    chk("pre_rst_cnt", 32'(digit_cnt), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(digit_cnt), 32'd0);
    chk("arst_buf", 32'(buf_bcd), 32'd0);
    chk("arst_out", 32'({entry_valid, key_strobe, key_err}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    key(8'h18, 1);
    chk("post_rst_strobe", 32'(s_seen), 32'd1);
    chk("post_rst_buf", 32'(buf_bcd), 32'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
